vga_plot_sink: RTL

//  Receiving end of the VGA plot interface driven by the drawing engines (fill/circle).
//  - Accepts (x, y, colour, plot) strobes and writes them into an internal

---
 rtl/vga_plot_sink.sv | 139 +++++++++++++
 1 files changed

// File: rtl/vga_plot_sink.sv
// Shadow framebuffer for the VGA plot interface: clipped pixel writes, a
// full-screen clear engine, a registered read-back port and saturating counters.
module vga_plot_sink #(
    parameter int WIDTH    = 160,
    parameter int HEIGHT   = 120,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          vga_x,
    input  logic [6:0]          vga_y,
    input  logic [COLOUR_W-1:0] vga_colour,
    input  logic                vga_plot,
    input  logic                clear_req,
    input  logic [COLOUR_W-1:0] clear_colour,
    output logic                busy,
    input  logic                rd_en,
    input  logic [7:0]          rd_x,
    input  logic [6:0]          rd_y,
    output logic [COLOUR_W-1:0] rd_data,
    output logic                rd_valid,
    output logic [15:0]         plot_count,
    output logic [15:0]         clip_count
);

    localparam int NPIX   = WIDTH * HEIGHT;
    localparam int ADDR_W = ($clog2(NPIX + 1) > 15) ? $clog2(NPIX + 1) : 15;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t state, next_state;

    logic [COLOUR_W-1:0] mem [NPIX];

    logic [ADDR_W-1:0]   clr_addr;
    logic [COLOUR_W-1:0] fill_colour;
    logic [ADDR_W-1:0]   plot_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic                plot_in_range;
    logic                rd_in_range;
    logic                clear_start;
    logic                plot_hit;
    logic                plot_miss;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [COLOUR_W-1:0] mem_wdata;

    // Range checks use the full port widths so x=255 / y=127 can never alias.
    assign plot_in_range = (int'(vga_x) < WIDTH) && (int'(vga_y) < HEIGHT);
    assign rd_in_range   = (int'(rd_x) < WIDTH) && (int'(rd_y) < HEIGHT);
    assign plot_addr     = ADDR_W'(vga_y) * ADDR_W'(WIDTH) + ADDR_W'(vga_x);
    assign rd_addr       = ADDR_W'(rd_y) * ADDR_W'(WIDTH) + ADDR_W'(rd_x);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (clr_addr == ADDR_W'(NPIX - 1)) next_state = RUN;
            RUN:     if (clear_req) next_state = CLEAR;
            default: next_state = CLEAR;
        endcase
    end

    // A clear request in RUN takes priority over a plot in the same cycle.
    always_comb begin
        busy        = (state == CLEAR);
        clear_start = 1'b0;
        plot_hit    = 1'b0;
        plot_miss   = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = clr_addr;
        mem_wdata   = fill_colour;
        case (state)
            CLEAR: mem_we = !rst;
            RUN: begin
                if (clear_req) begin
                    clear_start = 1'b1;
                end else if (vga_plot) begin
                    if (plot_in_range) begin
                        plot_hit  = 1'b1;
                        mem_we    = !rst;
                        mem_addr  = plot_addr;
                        mem_wdata = vga_colour;
                    end else begin
                        plot_miss = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_addr    <= '0;
            fill_colour <= '0;
            plot_count  <= '0;
            clip_count  <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
        end else begin
            if (clear_start) begin
                clr_addr    <= '0;
                fill_colour <= clear_colour;
                plot_count  <= '0;
                clip_count  <= '0;
            end else begin
                if (state == CLEAR) begin
                    clr_addr <= clr_addr + 1'b1;
                end
                if (plot_hit && plot_count != 16'hFFFF) begin
                    plot_count <= plot_count + 16'd1;
                end
                if (plot_miss && clip_count != 16'hFFFF) begin
                    clip_count <= clip_count + 16'd1;
                end
            end
            // Read-before-write: a same-cycle write lands after this sample.
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_in_range ? mem[rd_addr] : '0;
            end
        end
    end

endmodule
